// File: rtl/psi_index_emitter.sv
// Scans a captured PSI intersection bit-vector from bit 0 upward and streams the
// index of every set bit over valid/ready, then reports the cardinality with a done pulse.
module psi_index_emitter #(
    parameter int W     = 10,
    parameter int IDX_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     vec,
    output logic             busy,
    output logic [IDX_W-1:0] idx,
    output logic             idx_valid,
    input  logic             idx_ready,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [W-1:0]       shadow_reg, shadow_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               idx_valid_reg, idx_valid_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               done_reg, done_next;
    logic               last_bit;

    assign last_bit = (ptr_reg == IDX_W'(W - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            shadow_reg    <= '0;
            ptr_reg       <= '0;
            idx_reg       <= '0;
            idx_valid_reg <= 1'b0;
            count_reg     <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            shadow_reg    <= shadow_next;
            ptr_reg       <= ptr_next;
            idx_reg       <= idx_next;
            idx_valid_reg <= idx_valid_next;
            count_reg     <= count_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shadow_next    = shadow_reg;
        ptr_next       = ptr_reg;
        idx_next       = idx_reg;
        idx_valid_next = idx_valid_reg;
        count_next     = count_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shadow_next = vec;
                    ptr_next    = '0;
                    count_next  = '0;
                    state_next  = SCAN;
                end
            end
            SCAN: begin
                if (shadow_reg[ptr_reg]) begin
                    idx_next       = ptr_reg;
                    idx_valid_next = 1'b1;
                    state_next     = EMIT;
                end else if (last_bit) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    ptr_next = ptr_reg + IDX_W'(1);
                end
            end
            EMIT: begin
                // idx/idx_valid stay frozen until the consumer takes the index
                if (idx_valid_reg && idx_ready) begin
                    count_next     = count_reg + CNT_W'(1);
                    idx_valid_next = 1'b0;
                    if (last_bit) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else begin
                        ptr_next   = ptr_reg + IDX_W'(1);
                        state_next = SCAN;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = (state_reg != IDLE);
    assign idx       = idx_reg;
    assign idx_valid = idx_valid_reg;
    assign count     = count_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_psi_index_emitter.sv
// Directed bench for psi_index_emitter: table of whole scans plus hand-written
// sequences for reset during EMIT and a start held across the done cycle.
module tb_psi_index_emitter;

    localparam int W     = 10;
    localparam int IDX_W = 4;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [W-1:0]     vec;
    logic             busy;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic             idx_ready;
    logic [CNT_W-1:0] count;
    logic             done;

    int checks = 0;
    int errors = 0;

    psi_index_emitter #(.W(W), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec       (vec),
        .busy      (busy),
        .idx       (idx),
        .idx_valid (idx_valid),
        .idx_ready (idx_ready),
        .count     (count),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] vec;
        int           ready_mode;   // 0: always ready, 1: ready only when cycle%3==0
        bit           retrig;       // pulse start with vec=3FF in cycle 3
        logic [W-1:0] exp_mask;
        int           exp_count;
        int           exp_done;     // cycle of done, counted from the start edge
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input vec_t t);
        int           c;
        int           hs;
        int           last;
        int           exp_idx;
        bit           got_done;
        bit           stalled;
        logic [IDX_W-1:0] held_idx;
        logic [W-1:0] emitted;
        vec       = t.vec;
        start     = 1'b1;
        idx_ready = 1'b0;
        tick();
        start    = 1'b0;
        vec      = ~t.vec;       // later vec changes must not affect the scan
        c        = 1;
        hs       = 0;
        last     = -1;
        got_done = 1'b0;
        stalled  = 1'b0;
        emitted  = '0;
        while (!got_done && c < 100) begin
            if (done) begin
                got_done = 1'b1;
                chk({t.name, " done_cycle"}, c, t.exp_done);
                chk({t.name, " final_count"}, count, t.exp_count);
                chk({t.name, " busy_at_done"}, busy, 0);
                chk({t.name, " emitted_set"}, emitted, t.exp_mask);
            end else begin
                chk({t.name, " busy"}, busy, 1);
                chk({t.name, " running_count"}, count, hs);
                if (stalled) begin
                    chk({t.name, " stall_valid"}, idx_valid, 1);
                    chk({t.name, " stall_idx"}, idx, held_idx);
                end
                idx_ready = (t.ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
                if (t.retrig && c == 3) begin
                    start = 1'b1;
                    vec   = '1;
                end else begin
                    start = 1'b0;
                end
                if (idx_valid) begin
                    if (idx_ready) begin
                        exp_idx = W;
                        for (int i = W - 1; i > last; i--)
                            if (t.exp_mask[i]) exp_idx = i;
                        chk({t.name, " idx"}, idx, exp_idx);
                        $display("%s: cycle %0d idx %0d accepted", t.name, c, idx);
                        last    = idx;
                        emitted[idx] = 1'b1;
                        hs++;
                        stalled = 1'b0;
                    end else begin
                        stalled  = 1'b1;
                        held_idx = idx;
                    end
                end
                tick();
                c++;
            end
        end
        if (!got_done) chk({t.name, " done_timeout"}, 0, 1);
        start = 1'b0;
        tick();
        chk({t.name, " done_one_cycle"}, done, 0);
        chk({t.name, " count_hold"}, count, t.exp_count);
        $display("%s: scan complete count %0d", t.name, count);
    endtask

    initial begin
        int  c;
        bit  found;
        tbl[0] = '{"zero",      10'b00_0000_0000, 0, 1'b0, 10'b00_0000_0000, 0, 11};
        tbl[1] = '{"ends",      10'b10_0000_0001, 0, 1'b0, 10'b10_0000_0001, 2, 13};
        tbl[2] = '{"ones_stall",10'h3FF,          1, 1'b0, 10'h3FF,         10, 31};
        tbl[3] = '{"retrig",    10'b00_0001_0100, 0, 1'b1, 10'b00_0001_0100, 2, 13};
        tbl[4] = '{"ones",      10'h3FF,          0, 1'b0, 10'h3FF,         10, 21};

        rst = 1'b1; start = 1'b0; vec = '0; idx_ready = 1'b0;
        tick();
        tick();
        chk("rst busy", busy, 0);
        chk("rst idx", idx, 0);
        chk("rst idx_valid", idx_valid, 0);
        chk("rst count", count, 0);
        chk("rst done", done, 0);
        $display("reset: busy %0d valid %0d count %0d", busy, idx_valid, count);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) run_scan(tbl[k]);

        // Reset while EMIT holds idx=3 after one earlier handshake
        vec = 10'b00_0000_1001; start = 1'b1; idx_ready = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (idx_valid && idx == 3) begin
                found = 1'b1;
                idx_ready = 1'b0;
            end else begin
                tick();
            end
        end
        chk("rstmid reached_idx3", found, 1);
        chk("rstmid count_before", count, 1);
        tick();
        chk("rstmid held_valid", idx_valid, 1);
        chk("rstmid held_idx", idx, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid idx_valid", idx_valid, 0);
        chk("rstmid count", count, 0);
        chk("rstmid busy", busy, 0);
        chk("rstmid idx", idx, 0);
        chk("rstmid done", done, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("rstmid no_done", done, 0);
        end
        $display("rstmid: abandoned scan, valid %0d count %0d", idx_valid, count);
        run_scan('{"after_rst", 10'b00_0000_0001, 0, 1'b0, 10'b00_0000_0001, 1, 12});

        // Start held high across the done cycle launches a second scan at once
        vec = 10'b00_0000_0010; start = 1'b1; idx_ready = 1'b1;
        tick();
        c = 1;
        while (!done && c < 50) begin
            tick();
            c++;
        end
        chk("held first_done_cycle", c, 12);
        chk("held first_count", count, 1);
        tick();
        c++;
        chk("held restart_busy", busy, 1);
        chk("held restart_count", count, 0);
        chk("held restart_done_low", done, 0);
        start = 1'b0;
        found = 1'b0;
        while (!done && c < 60) begin
            if (idx_valid) begin
                chk("held second_idx", idx, 1);
                found = 1'b1;
            end
            tick();
            c++;
        end
        chk("held second_emitted", found, 1);
        chk("held second_done_cycle", c, 24);
        chk("held second_count", count, 1);
        $display("held: second scan done at cycle %0d count %0d", c, count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
